// File: rtl/drlp_sld_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : drlp_sld_ctrl_pkg
//  Description : Shared constants and types for the DRLP sliding register
//                file sequencer (FSM encoding, mode and fill-length values).
//  Revision    : 1.0 - initial release
// ============================================================================
package drlp_sld_ctrl_pkg;

  // Buffer read latency the sequencer is built around
  localparam int RD_LATENCY_FIXED = 1;

  // Register-file modes: 00 selects a 3x3 kernel, all others a 6-column kernel
  localparam logic [1:0] MODE_3X3 = 2'b00;

  // Columns that must be loaded before the first window of a band is complete
  localparam logic [2:0] K3 = 3'd3;
  localparam logic [2:0] K6 = 3'd6;

  // Sequencer FSM encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_SLIDE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Register-file configuration held for the duration of a job
  typedef struct packed {
    logic [1:0] mode;
    logic       sel3x3;
  } rf_cfg_t;

  // Fill length for a given register-file mode
  function automatic logic [2:0] fill_len(input logic [1:0] mode);
    return (mode == MODE_3X3) ? K3 : K6;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drlp_sld_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : drlp_sld_ctrl_if
//  Description : Buffer-read, register-file control and window handshake
//                between the sliding-window sequencer and its datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
interface drlp_sld_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  shift;
  logic [1:0]            mode;
  logic                  sel3x3;
  logic                  win_valid;
  logic                  win_last;
  logic                  pe_ready;

  // Sequencer side
  modport master (
    output rd_en, rd_addr, shift, mode, sel3x3, win_valid, win_last,
    input  pe_ready
  );

  // Buffer / register file / PE array side
  modport slave (
    input  rd_en, rd_addr, shift, mode, sel3x3, win_valid, win_last,
    output pe_ready
  );
endinterface
`default_nettype wire

// File: rtl/drlp_sld_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : drlp_sld_addr_gen
//  Description : Column/band counters and activation-buffer read address
//                (base + band*W + col) built from a running row-base register.
//  Revision    : 1.0 - initial release
// ============================================================================
module drlp_sld_addr_gen #(
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic                  i_adv,
  input  logic                  i_wrap,
  input  logic [DIM_WIDTH-1:0]  i_width,
  output logic [DIM_WIDTH-1:0]  o_col,
  output logic [DIM_WIDTH-1:0]  o_band,
  output logic [ADDR_WIDTH-1:0] o_rd_addr
);

  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [DIM_WIDTH-1:0]  band_q, band_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;

  // Advance one column per issued read; the last column steps to the next band
  always_comb begin
    col_d      = col_q;
    band_d     = band_q;
    row_base_d = row_base_q;
    if (i_load) begin
      col_d      = '0;
      band_d     = '0;
      row_base_d = i_base_addr;
    end else if (i_adv) begin
      if (i_wrap) begin
        col_d      = '0;
        band_d     = band_q + DIM_WIDTH'(1);
        row_base_d = row_base_q + ADDR_WIDTH'(i_width);
      end else begin
        col_d = col_q + DIM_WIDTH'(1);
      end
    end
  end

  // Counter state
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      col_q      <= '0;
      band_q     <= '0;
      row_base_q <= '0;
    end else begin
      col_q      <= col_d;
      band_q     <= band_d;
      row_base_q <= row_base_d;
    end
  end

  assign o_col     = col_q;
  assign o_band    = band_q;
  assign o_rd_addr = row_base_q + ADDR_WIDTH'(col_q);

endmodule
`default_nettype wire

// File: rtl/drlp_sld_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : drlp_sld_ctrl
//  Description : Job sequencer for the 6x6 sliding register file. Issues
//                column reads, drives shift/mode/3x3 controls one cycle after
//                each read, and flags complete convolution windows.
//  Revision    : 1.0 - initial release
// ============================================================================
module drlp_sld_ctrl
  import drlp_sld_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic                  i_3x3,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [DIM_WIDTH-1:0]  i_width,
  input  logic [DIM_WIDTH-1:0]  i_bands,
  output logic                  o_busy,
  output logic                  o_done,
  drlp_sld_ctrl_if.master       sld
);

  // Only a 1-cycle buffer is supported; any other value suppresses shifting
  localparam logic LAT_OK = (RD_LATENCY == RD_LATENCY_FIXED);

  logic [2:0]           state_q, state_d;
  logic [2:0]           fill_cnt_q, fill_cnt_d;
  logic                 drain_cnt_q, drain_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q;
  rf_cfg_t              cfg_q;
  logic [DIM_WIDTH-1:0] width_q, bands_q;
  logic                 shift_q, cand_q, cand_last_q;
  logic                 win_valid_q, win_last_q;

  logic                 w_accept, w_band_end, w_rd_en;
  logic                 w_last_col, w_last_band, w_cand;
  logic [2:0]           w_k;
  logic [DIM_WIDTH-1:0] w_col, w_band;

  drlp_sld_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_accept),
    .i_base_addr (i_base_addr),
    .i_adv       (w_rd_en),
    .i_wrap      (w_last_col),
    .i_width     (width_q),
    .o_col       (w_col),
    .o_band      (w_band),
    .o_rd_addr   (sld.rd_addr)
  );

  assign w_k         = fill_len(cfg_q.mode);
  assign w_last_col  = (w_col == width_q - DIM_WIDTH'(1));
  assign w_last_band = (w_band == bands_q - DIM_WIDTH'(1));
  // A read at column >= K-1 completes a window once it has been shifted in
  assign w_cand      = (w_col >= DIM_WIDTH'(w_k - 3'd1));
  // Fill reads are unconditional; slide reads wait for the PE array
  assign w_rd_en     = (state_q == ST_FILL) ||
                       ((state_q == ST_SLIDE) && sld.pe_ready);

  // Next-state logic for the job sequencer
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    busy_d      = busy_q;
    w_accept    = 1'b0;
    w_band_end  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          busy_d      = 1'b1;
          fill_cnt_d  = '0;
          drain_cnt_d = 1'b0;
          state_d     = ((i_width == '0) || (i_bands == '0)) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        fill_cnt_d = fill_cnt_q + 3'd1;
        // A band narrower than K ends here with no windows
        if (w_last_col) begin
          w_band_end = 1'b1;
        end else if (fill_cnt_q == w_k - 3'd1) begin
          state_d = ST_SLIDE;
        end
      end
      ST_SLIDE: begin
        if (sld.pe_ready && w_last_col) begin
          w_band_end = 1'b1;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (w_band_end) begin
      fill_cnt_d  = '0;
      drain_cnt_d = 1'b0;
      state_d     = w_last_band ? ST_DRAIN : ST_FILL;
    end
  end

  // FSM, job status and latched job configuration
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      fill_cnt_q  <= '0;
      drain_cnt_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_q       <= '0;
      width_q     <= '0;
      bands_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= (state_q == ST_DONE);
      if (w_accept) begin
        cfg_q.mode   <= i_mode;
        cfg_q.sel3x3 <= i_3x3;
        width_q      <= i_width;
        bands_q      <= i_bands;
      end
    end
  end

  // Shift follows each read by the buffer latency; windows appear one cycle later
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      shift_q     <= 1'b0;
      cand_q      <= 1'b0;
      cand_last_q <= 1'b0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      shift_q     <= w_rd_en && LAT_OK;
      cand_q      <= w_rd_en && w_cand;
      cand_last_q <= w_rd_en && w_cand && w_last_col && w_last_band;
      win_valid_q <= cand_q;
      win_last_q  <= cand_last_q;
    end
  end

  assign sld.rd_en     = w_rd_en;
  assign sld.shift     = shift_q;
  assign sld.mode      = cfg_q.mode;
  assign sld.sel3x3    = cfg_q.sel3x3;
  assign sld.win_valid = win_valid_q;
  assign sld.win_last  = win_last_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_drlp_sld_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_drlp_sld_ctrl
//  Description : Scoreboard bench for drlp_sld_ctrl: jobs push expected reads,
//                window flags and completions; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_drlp_sld_ctrl;

  localparam int AW = 10;
  localparam int DW = 6;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          win;
    logic          last;
  } rd_exp_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic          sel   = 1'b0;
  logic [AW-1:0] base  = '0;
  logic [DW-1:0] width = '0;
  logic [DW-1:0] bands = '0;
  logic          busy, done;

  drlp_sld_ctrl_if #(.ADDR_WIDTH(AW)) sld ();

  drlp_sld_ctrl #(
    .ADDR_WIDTH (AW),
    .DIM_WIDTH  (DW),
    .RD_LATENCY (1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst_n),
    .i_start     (start),
    .i_mode      (mode),
    .i_3x3       (sel),
    .i_base_addr (base),
    .i_width     (width),
    .i_bands     (bands),
    .o_busy      (busy),
    .o_done      (done),
    .sld         (sld)
  );

  always #5 clk = ~clk;

  rd_exp_t    rd_q[$];
  bit         done_exp[$];
  int         checks = 0, failures = 0;
  bit         sb_en = 1'b0;
  int         cyc = 0, last_rd_cyc = 0, done_cnt = 0;
  int         shift_cnt = 0, win_cnt = 0, stall_rd = 0;
  logic       prev_rd = 1'b0, p1w = 1'b0, p1l = 1'b0, p2w = 1'b0, p2l = 1'b0;
  logic [1:0] exp_mode = 2'b00;
  logic       exp_sel = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"},     32'(sld.rd_en),     0);
    chk({tag, "_rd_addr"},   32'(sld.rd_addr),   0);
    chk({tag, "_shift"},     32'(sld.shift),     0);
    chk({tag, "_mode"},      32'(sld.mode),      0);
    chk({tag, "_3x3"},       32'(sld.sel3x3),    0);
    chk({tag, "_win_valid"}, 32'(sld.win_valid), 0);
    chk({tag, "_win_last"},  32'(sld.win_last),  0);
    chk({tag, "_busy"},      32'(busy),          0);
    chk({tag, "_done"},      32'(done),          0);
  endtask

  // Monitor: pops expected reads/completions and tracks shift and window timing
  always @(negedge clk) begin : mon
    rd_exp_t e;
    if (!rst_n) begin
      prev_rd = 1'b0; p1w = 1'b0; p1l = 1'b0; p2w = 1'b0; p2l = 1'b0;
    end else if (sb_en) begin
      cyc++;
      chk("shift_lag", 32'(sld.shift), 32'(prev_rd));
      if (sld.win_valid || sld.win_last || p2w)
        chk("window", 32'({sld.win_valid, sld.win_valid & sld.win_last}), 32'({p2w, p2l}));
      if (sld.shift) shift_cnt++;
      if (sld.win_valid) win_cnt++;
      p2w = p1w; p2l = p1l; p1w = 1'b0; p1l = 1'b0;
      if (sld.rd_en) begin
        if (!sld.pe_ready) stall_rd++;
        last_rd_cyc = cyc;
        if (rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected: read at 0x%0h, expected no read", sld.rd_addr);
        end else begin
          e = rd_q.pop_front();
          chk("rd_addr", 32'(sld.rd_addr), 32'(e.addr));
          p1w = e.win; p1l = e.last;
        end
      end
      prev_rd = sld.rd_en;
      if (busy) begin
        chk("cfg_mode", 32'(sld.mode), 32'(exp_mode));
        chk("cfg_3x3", 32'(sld.sel3x3), 32'(exp_sel));
      end
      if (done) begin
        done_cnt++;
        chk("busy_at_done", 32'(busy), 0);
        if (done_exp.size() == 0) begin
          checks++; failures++;
          $display("FAIL done_unexpected: o_done=1, expected 0");
        end else if (done_exp.pop_front()) begin
          chk("done_latency", 32'(cyc - last_rd_cyc), 4);
        end
      end
    end
  end

  task automatic run_job(input logic [1:0] m, input logic s, input logic [AW-1:0] b0,
                         input int W, input int B, input int stall_at, input int stall_len,
                         input int busy_at);
    int kk, nwin, d0;
    rd_exp_t e;
    kk   = (m == 2'b00) ? 3 : 6;
    nwin = 0;
    for (int b = 0; b < B; b++) begin
      for (int c = 0; c < W; c++) begin
        e.addr = AW'(int'(b0) + b * W + c);
        e.win  = (W >= kk) && (c >= kk - 1);
        e.last = e.win && (b == B - 1) && (c == W - 1);
        if (e.win) nwin++;
        rd_q.push_back(e);
      end
    end
    done_exp.push_back((W != 0) && (B != 0));
    exp_mode = m; exp_sel = s;
    shift_cnt = 0; win_cnt = 0; stall_rd = 0;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; mode = m; sel = s; base = b0; width = DW'(W); bands = DW'(B);
    sld.pe_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      sld.pe_ready = !(stall_at >= 0 && k >= stall_at && k < stall_at + stall_len);
      if (k == busy_at) begin
        start = 1'b1; mode = ~m; sel = ~s; base = b0 + AW'(100); width = DW'(W + 1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    sld.pe_ready = 1'b1;
    chk("job_done", 32'(done_cnt - d0), 1);
    chk("rd_leftover", 32'(rd_q.size()), 0);
    chk("shift_count", 32'(shift_cnt), 32'(W * B));
    chk("win_count", 32'(win_cnt), 32'(nwin));
    chk("stall_reads", 32'(stall_rd), 0);
    rd_q.delete();
  endtask

  initial begin
    sld.pe_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    sb_en = 1'b1;

    // 6-column mode, single band, no stalls
    run_job(2'b01, 1'b0, 10'h010, 8, 1, -1, 0, -1);
    // 3x3 low half, two bands with a fill restart between them
    run_job(2'b00, 1'b1, 10'h000, 5, 2, -1, 0, -1);
    // PE back-pressure for 4 cycles in SLIDE
    run_job(2'b01, 1'b0, 10'h100, 8, 1, 7, 4, -1);
    // Band narrower than K: reads only, no windows
    run_job(2'b10, 1'b0, 10'h020, 4, 1, -1, 0, -1);
    // Empty jobs
    run_job(2'b10, 1'b0, 10'h030, 0, 1, -1, 0, -1);
    run_job(2'b00, 1'b0, 10'h040, 5, 0, -1, 0, -1);
    // W == K, address wrap, and a start pulse while busy
    run_job(2'b11, 1'b1, 10'h3FC, 6, 2, -1, 0, 2);

    // Reset pulsed in the middle of SLIDE
    sb_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; sel = 1'b1; base = 10'h080; width = 6'd8; bands = 6'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    rd_q.delete();
    done_exp.delete();
    sb_en = 1'b1;
    run_job(2'b00, 1'b0, 10'h050, 4, 3, -1, 0, -1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
